// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - single-outstanding AXI-style SRAM slave with programmable response latency
//
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   AW_ADDR/AW_VALID/AW_READY         write address channel
//   W_DATA/W_STRB/W_VALID/W_READY     write data channel (byte strobes)
//   B_VALID/B_READY                   write response channel
//   AR_ADDR/AR_VALID/AR_READY         read address channel
//   R_DATA/R_VALID/R_READY            read data channel
//   access_err                        pulses in the accept cycle of an out-of-range access

module axi_sram_slave #(
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] AW_ADDR,
    input  logic        AW_VALID,
    output logic        AW_READY,
    input  logic [63:0] W_DATA,
    input  logic [7:0]  W_STRB,
    input  logic        W_VALID,
    output logic        W_READY,
    output logic        B_VALID,
    input  logic        B_READY,
    input  logic [63:0] AR_ADDR,
    input  logic        AR_VALID,
    output logic        AR_READY,
    output logic [63:0] R_DATA,
    output logic        R_VALID,
    input  logic        R_READY,
    output logic        access_err
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        WR_WAIT,
        WR_RESP
    } state_t;

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic                  in_range_q;
    logic [63:0]           wdata_q;
    logic [7:0]            wstrb_q;
    logic [63:0]           rdata_q;
    logic                  r_valid_q;
    logic                  b_valid_q;

    logic [63:0] mem [2**DEPTH_LOG2];

    logic                  wr_go;
    logic                  rd_go;
    logic [63:0]           acc_addr;
    logic [63:0]           acc_off;
    logic                  acc_in_range;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic                  wait_done;
    logic                  mem_we;
    logic                  unused_low_bits;

    // A write needs both address and data present; it also wins over a
    // concurrent read. Gated by rst_n so nothing is acknowledged that the
    // reset would then discard.
    assign wr_go = rst_n && (state_q == IDLE) && AW_VALID && W_VALID;
    assign rd_go = rst_n && (state_q == IDLE) && AR_VALID && !(AW_VALID && W_VALID);

    assign acc_addr = wr_go ? AW_ADDR : AR_ADDR;
    assign acc_off  = acc_addr - BASE_ADDR;
    // Checking the offset's high bits avoids overflow of BASE_ADDR + size.
    assign acc_in_range = (acc_addr >= BASE_ADDR) &&
                          (acc_off[63:DEPTH_LOG2+3] == '0);
    assign acc_idx  = acc_off[DEPTH_LOG2+2:3];
    assign unused_low_bits = ^acc_off[2:0];

    assign wait_done = (cnt_q == 4'd0);
    assign mem_we    = rst_n && (state_q == WR_WAIT) && wait_done && in_range_q;

    assign AW_READY   = wr_go;
    assign W_READY    = wr_go;
    assign AR_READY   = rd_go;
    assign access_err = (wr_go || rd_go) && !acc_in_range;

    assign R_DATA  = rdata_q;
    assign R_VALID = r_valid_q;
    assign B_VALID = b_valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            rdata_q   <= 64'h0;
            r_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_go) begin
                        state_q    <= WR_WAIT;
                        cnt_q      <= 4'(LATENCY);
                        idx_q      <= acc_idx;
                        in_range_q <= acc_in_range;
                        wdata_q    <= W_DATA;
                        wstrb_q    <= W_STRB;
                    end else if (rd_go) begin
                        state_q    <= RD_WAIT;
                        cnt_q      <= 4'(LATENCY);
                        idx_q      <= acc_idx;
                        in_range_q <= acc_in_range;
                    end
                end
                RD_WAIT: begin
                    if (wait_done) begin
                        rdata_q   <= in_range_q ? mem[idx_q] : 64'h0;
                        r_valid_q <= 1'b1;
                        state_q   <= RD_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RD_RESP: begin
                    if (R_READY) begin
                        r_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                WR_WAIT: begin
                    if (wait_done) begin
                        b_valid_q <= 1'b1;
                        state_q   <= WR_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                WR_RESP: begin
                    if (B_READY) begin
                        b_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (wstrb_q[b]) begin
                    mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - randomized self-checking bench for axi_sram_slave

module tb_axi_sram_slave;

    localparam logic [63:0] BASE    = 64'h8000_0000;
    localparam int          DEPTH   = 12;
    localparam int          LAT     = 2;
    localparam int          TIMEOUT = 40;

    logic        clk;
    logic        rst_n;
    logic [63:0] AW_ADDR;
    logic        AW_VALID;
    logic        AW_READY;
    logic [63:0] W_DATA;
    logic [7:0]  W_STRB;
    logic        W_VALID;
    logic        W_READY;
    logic        B_VALID;
    logic        B_READY;
    logic [63:0] AR_ADDR;
    logic        AR_VALID;
    logic        AR_READY;
    logic [63:0] R_DATA;
    logic        R_VALID;
    logic        R_READY;
    logic        access_err;

    axi_sram_slave #(
        .BASE_ADDR  (BASE),
        .DEPTH_LOG2 (DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .AW_ADDR    (AW_ADDR),
        .AW_VALID   (AW_VALID),
        .AW_READY   (AW_READY),
        .W_DATA     (W_DATA),
        .W_STRB     (W_STRB),
        .W_VALID    (W_VALID),
        .W_READY    (W_READY),
        .B_VALID    (B_VALID),
        .B_READY    (B_READY),
        .AR_ADDR    (AR_ADDR),
        .AR_VALID   (AR_VALID),
        .AR_READY   (AR_READY),
        .R_DATA     (R_DATA),
        .R_VALID    (R_VALID),
        .R_READY    (R_READY),
        .access_err (access_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference memory: word index -> contents.
    logic [63:0] mdl [int];
    logic [63:0] pool [20];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit in_rng(input logic [63:0] a);
        return (a >= BASE) && (a < BASE + 64'd8 * (64'd1 << DEPTH));
    endfunction

    function automatic int widx(input logic [63:0] a);
        return int'((a - BASE) / 64'd8);
    endfunction

    function automatic logic [63:0] mdl_read(input logic [63:0] a);
        if (!in_rng(a)) return 64'h0;
        if (!mdl.exists(widx(a))) return 64'hx;
        return mdl[widx(a)];
    endfunction

    task automatic mdl_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] w;
        if (!in_rng(a)) return;
        w = mdl.exists(widx(a)) ? mdl[widx(a)] : 64'h0;
        for (int b = 0; b < 8; b++)
            if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        mdl[widx(a)] = w;
    endtask

    // Entered just after the accept edge. Measures response latency, holds
    // READY low for 'hold' cycles (probing that no new read is accepted),
    // then completes the handshake. hold==0 raises READY before VALID.
    task automatic wait_resp(input bit is_rd, input logic [63:0] exp, input int hold);
        int          cnt;
        logic        v;
        logic [63:0] first;
        logic        prev_ar;
        cnt = 0;
        if (hold == 0) begin
            if (is_rd) R_READY = 1'b1; else B_READY = 1'b1;
        end
        @(negedge clk);
        v = is_rd ? R_VALID : B_VALID;
        while (!v && cnt < TIMEOUT) begin
            @(negedge clk);
            cnt++;
            v = is_rd ? R_VALID : B_VALID;
        end
        check(is_rd ? "r_latency" : "b_latency", 64'(cnt), 64'(LAT + 1));
        if (is_rd) check("r_data", R_DATA, exp);
        first   = R_DATA;
        prev_ar = AR_VALID;
        for (int i = 0; i < hold; i++) begin
            AR_VALID = 1'b1;
            #1;
            check("no_accept_in_resp", {63'h0, AR_READY}, 64'h0);
            if (is_rd) begin
                check("r_valid_hold", {63'h0, R_VALID}, 64'h1);
                check("r_data_hold", R_DATA, first);
            end else begin
                check("b_valid_hold", {63'h0, B_VALID}, 64'h1);
            end
            @(negedge clk);
        end
        AR_VALID = prev_ar;
        if (is_rd) R_READY = 1'b1; else B_READY = 1'b1;
        @(negedge clk);
        check(is_rd ? "r_valid_drop" : "b_valid_drop",
              {63'h0, (is_rd ? R_VALID : B_VALID)}, 64'h0);
        R_READY = 1'b0;
        B_READY = 1'b0;
    endtask

    task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s, input int hold);
        @(negedge clk);
        AW_ADDR = a; W_DATA = d; W_STRB = s;
        AW_VALID = 1'b1; W_VALID = 1'b1;
        #1;
        check("aw_ready", {63'h0, AW_READY}, 64'h1);
        check("w_ready", {63'h0, W_READY}, 64'h1);
        check("wr_access_err", {63'h0, access_err}, {63'h0, !in_rng(a)});
        @(posedge clk);
        #1;
        AW_VALID = 1'b0; W_VALID = 1'b0;
        mdl_write(a, d, s);
        wait_resp(1'b0, 64'h0, hold);
    endtask

    task automatic do_read(input logic [63:0] a, input int hold);
        @(negedge clk);
        AR_ADDR = a; AR_VALID = 1'b1;
        #1;
        check("ar_ready", {63'h0, AR_READY}, 64'h1);
        check("rd_access_err", {63'h0, access_err}, {63'h0, !in_rng(a)});
        @(posedge clk);
        #1;
        AR_VALID = 1'b0;
        wait_resp(1'b1, mdl_read(a), hold);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        logic [63:0] d;
        int          k;

        rst_n = 1'b0;
        AW_ADDR = '0; AW_VALID = 1'b0; W_DATA = '0; W_STRB = '0; W_VALID = 1'b0;
        B_READY = 1'b0; AR_ADDR = '0; AR_VALID = 1'b0; R_READY = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_r_valid", {63'h0, R_VALID}, 64'h0);
        check("rst_b_valid", {63'h0, B_VALID}, 64'h0);
        check("rst_r_data", R_DATA, 64'h0);
        check("rst_access_err", {63'h0, access_err}, 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) pool[i] = BASE + 64'(8 * i);
        pool[16] = BASE + 64'd8 * 64'd4095;
        pool[17] = 64'h7FFF_FFF8;
        pool[18] = BASE + 64'h8000;
        pool[19] = 64'h0;

        // Basic write then read of the same word.
        do_write(64'h8000_0010, 64'h1122334455667788, 8'hFF, 0);
        do_read(64'h8000_0010, 0);

        // Strobe merge.
        do_write(64'h8000_0020, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1);
        do_write(64'h8000_0020, 64'h0, 8'h0F, 0);
        do_read(64'h8000_0020, 2);

        // Known contents for every in-range pool word.
        for (int i = 0; i < 17; i++)
            do_write(pool[i], {$urandom, $urandom}, 8'hFF, 0);

        // Half a transaction must not be accepted.
        @(negedge clk);
        AW_ADDR = pool[3]; AW_VALID = 1'b1; #1;
        check("aw_only_aw_ready", {63'h0, AW_READY}, 64'h0);
        check("aw_only_w_ready", {63'h0, W_READY}, 64'h0);
        AW_VALID = 1'b0; W_VALID = 1'b1; W_DATA = 64'hDEAD; W_STRB = 8'hFF; #1;
        check("w_only_w_ready", {63'h0, W_READY}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        check("w_only_no_b", {63'h0, B_VALID}, 64'h0);
        W_VALID = 1'b0;
        do_read(pool[3], 1);

        // Write wins over simultaneous read; the read then sees new data.
        @(negedge clk);
        d = 64'hA5A5_0000_1234_5678;
        AW_ADDR = pool[5]; W_DATA = d; W_STRB = 8'hFF; AW_VALID = 1'b1; W_VALID = 1'b1;
        AR_ADDR = pool[5]; AR_VALID = 1'b1;
        #1;
        check("both_aw_ready", {63'h0, AW_READY}, 64'h1);
        check("both_ar_ready", {63'h0, AR_READY}, 64'h0);
        @(posedge clk);
        #1;
        AW_VALID = 1'b0; W_VALID = 1'b0;
        mdl_write(pool[5], d, 8'hFF);
        wait_resp(1'b0, 64'h0, 2);
        #1;
        check("ar_after_b", {63'h0, AR_READY}, 64'h1);
        @(posedge clk);
        #1;
        AR_VALID = 1'b0;
        wait_resp(1'b1, d, 0);

        // Long R_READY stall.
        do_read(pool[7], 5);

        // Out-of-range accesses.
        do_read(64'h7FFF_FFF8, 0);
        do_write(64'h8000_8000, 64'hCAFE_F00D_CAFE_F00D, 8'hFF, 0);
        do_read(BASE, 0);

        // Reset during RD_WAIT aborts the read.
        @(negedge clk);
        AR_ADDR = pool[2]; AR_VALID = 1'b1;
        @(posedge clk);
        #1;
        AR_VALID = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (R_VALID) k++;
        end
        check("rst_rd_no_r_valid", 64'(k), 64'h0);
        do_read(pool[2], 0);

        // Reset during WR_WAIT must not modify memory.
        @(negedge clk);
        AW_ADDR = pool[9]; W_DATA = 64'h0BAD_0BAD_0BAD_0BAD; W_STRB = 8'hFF;
        AW_VALID = 1'b1; W_VALID = 1'b1;
        @(posedge clk);
        #1;
        AW_VALID = 1'b0; W_VALID = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (B_VALID) k++;
        end
        check("rst_wr_no_b_valid", 64'(k), 64'h0);
        do_read(pool[9], 0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 80; n++) begin
            a = pool[$urandom_range(0, 19)] | 64'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1)
                do_write(a, {$urandom, $urandom}, 8'($urandom_range(0, 255)),
                         $urandom_range(0, 3));
            else
                do_read(a, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
